// File: rtl/pipe_trace_pkg.sv
// Shared types and field layout for the pipeline trace buffer.
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_LOAD,
    ST_READ
  } state_t;

  // Field positions within an entry, counted in DATA_W units from the LSB.
  localparam int PC_FIELD    = 2;
  localparam int INSTR_FIELD = 1;
  localparam int ALU_FIELD   = 0;

  function automatic int entry_w(input int data_w);
    return 3 * data_w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: one synchronous write port, one registered read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 96,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset; it doubles as the visible rd_data.
  always_ff @(posedge clk) begin
    if (rst)        r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Trace capture for the 5-stage CPU: circular history, PC trigger, post-window,
// then an oldest-first readout over valid/ready.
//
// state    | meaning
// ST_IDLE  | no capture, waiting for arm
// ST_ARMED | capturing, watching for trigger PC
// ST_POST  | capturing the post-trigger entries
// ST_LOAD  | fetching the oldest entry into rd_data
// ST_READ  | presenting entries to the consumer
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cap_valid,
  input  logic [DATA_W-1:0]         cap_pc,
  input  logic [DATA_W-1:0]         cap_instr,
  input  logic [DATA_W-1:0]         cap_alu,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [DATA_W-1:0]         trig_pc,
  output logic                      armed,
  output logic                      done,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [3*DATA_W-1:0]       rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(DATA_W);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_post_cnt, r_remaining;
  logic          w_cap, w_trig, w_rd_en, w_wr_en;
  logic [AW-1:0] w_rd_addr, w_oldest;
  logic [EW-1:0] w_wr_data;

  assign w_cap    = cap_valid && (r_state == ST_ARMED || r_state == ST_POST);
  assign w_trig   = cap_valid && (r_state == ST_ARMED) && (cap_pc == trig_pc);
  assign w_wr_en  = w_cap && !abort;
  // A full window wraps to wr_ptr itself since count's low bits are zero.
  assign w_oldest = r_wr_ptr - r_count[AW-1:0];

  assign w_wr_data[PC_FIELD*DATA_W    +: DATA_W] = cap_pc;
  assign w_wr_data[INSTR_FIELD*DATA_W +: DATA_W] = cap_instr;
  assign w_wr_data[ALU_FIELD*DATA_W   +: DATA_W] = cap_alu;

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_rd_ptr;
    case (r_state)
      ST_IDLE:  if (arm) w_state_nxt = ST_ARMED;
      ST_ARMED: if (w_trig) w_state_nxt = (POST_TRIG == 0) ? ST_LOAD : ST_POST;
      ST_POST:  if (cap_valid && r_post_cnt == CW'(POST_TRIG - 1)) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        w_rd_en     = 1'b1;
        w_rd_addr   = w_oldest;
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        if (rd_ready) begin
          if (r_remaining > CW'(1)) w_rd_en = 1'b1;
          else                      w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_rd_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_post_cnt  <= '0;
      r_remaining <= '0;
    end else if (abort) begin
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
          end
        end
        ST_ARMED, ST_POST: begin
          if (cap_valid) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
            r_post_cnt <= (r_state == ST_ARMED) ? '0 : r_post_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          r_rd_ptr    <= w_oldest + 1'b1;
          r_remaining <= r_count;
        end
        ST_READ: begin
          if (rd_ready && r_remaining > CW'(1)) begin
            r_rd_ptr    <= r_rd_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (w_wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (rd_data)
  );

  assign armed    = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign done     = (r_state == ST_LOAD) || (r_state == ST_READ);
  assign rd_valid = (r_state == ST_READ);
  assign count    = r_count;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Randomized bench for pipe_trace_buffer against a queue-based history model.
module tb_pipe_trace_buffer;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int POST_TRIG = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cap_valid = 1'b0;
  logic [DATA_W-1:0] cap_pc = '0, cap_instr = '0, cap_alu = '0;
  logic              arm = 1'b0, abort = 1'b0;
  logic [DATA_W-1:0] trig_pc = '0;
  logic              armed, done, rd_valid;
  logic              rd_ready = 1'b0;
  logic [CW-1:0]     count;
  logic [3*DATA_W-1:0] rd_data;

  pipe_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc),
    .cap_instr(cap_instr), .cap_alu(cap_alu), .arm(arm), .abort(abort),
    .trig_pc(trig_pc), .armed(armed), .done(done), .count(count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: full capture history since the last arm; the readout window is its tail.
  logic [95:0] hist[$];
  int m_mode      = 0;  // 0 idle, 1 capturing, 2 frozen/reading
  bit m_trig      = 0;
  int m_post_left = 0;
  int m_count     = 0;

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [31:0] pc);
    logic [31:0] ins, alu;
    ins = $urandom;
    alu = $urandom;
    cap_valid = 1'b1; cap_pc = pc; cap_instr = ins; cap_alu = alu;
    if (m_mode == 1) begin
      hist.push_back({pc, ins, alu});
      m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
      if (m_trig) begin
        m_post_left--;
        if (m_post_left == 0) m_mode = 2;
      end else if (pc == trig_pc) begin
        m_trig = 1;
        m_post_left = POST_TRIG;
        if (POST_TRIG == 0) m_mode = 2;
      end
    end
    step();
    cap_valid = 1'b0;
    check_val("count", 96'(count), 96'(m_count));
  endtask

  task automatic idle_cycle();
    cap_valid = 1'b0;
    cap_pc = $urandom;
    step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    if (m_mode == 0) begin
      hist.delete();
      m_count = 0; m_mode = 1; m_trig = 0;
    end
    step();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    hist.delete();
    m_count = 0; m_mode = 0; m_trig = 0;
    step();
    abort = 1'b0;
  endtask

  // mode 0: always ready, 1: toggle ready, 2: random ready
  task automatic read_out(input int mode);
    logic [95:0] exp_q[$];
    logic [95:0] hold;
    logic        rdy;
    int          guard;
    exp_q = hist;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    rd_ready = 1'b0;
    guard = 0;
    while (!rd_valid && guard < 10) begin step(); guard++; end
    check_val("rd_valid_start", 96'(rd_valid), 96'(1));
    for (int b = 0; b < 200 && exp_q.size() > 0; b++) begin
      check_val("rd_valid", 96'(rd_valid), 96'(1));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(b % 2) : 1'($urandom_range(0, 1));
      rd_ready = rdy;
      hold = rd_data;
      step();
      if (rdy) check_val("rd_data", hold, exp_q.pop_front());
      else     check_val("rd_hold", rd_data, hold);
    end
    rd_ready = 1'b0;
    check_val("rd_left", 96'(exp_q.size()), 96'(0));
    check_val("rd_end", 96'({rd_valid, armed, done}), 96'(0));
    m_mode = 0;
  endtask

  task automatic scen_basic();
    trig_pc = 32'h08;
    do_arm();
    check_val("armed", 96'(armed), 96'(1));
    for (int i = 0; i < 5; i++) cap(32'(4 * i));
    check_val("load_lat", 96'({done, rd_valid}), 96'(2'b10));
    step();
    check_val("first_valid", 96'({done, rd_valid}), 96'(2'b11));
    read_out(0);
  endtask

  task automatic scen_wrap(input int mode);
    trig_pc = 32'h3C;
    do_arm();
    for (int i = 0; i < 20; i++) cap(32'(4 * i));
    check_val("wrap_count", 96'(count), 96'(DEPTH));
    read_out(mode);
  endtask

  initial begin
    // 1. reset with random inputs, arm alongside rst ignored
    for (int i = 0; i < 3; i++) begin
      arm = 1'b1; cap_valid = 1'($urandom_range(0, 1)); cap_pc = $urandom;
      abort = 1'($urandom_range(0, 1)); rd_ready = 1'($urandom_range(0, 1));
      trig_pc = cap_pc;
      step();
    end
    check_val("rst_ctl", 96'({armed, done, rd_valid, count}), 96'(0));
    check_val("rst_data", rd_data, 96'(0));
    rst = 1'b0; arm = 1'b0; abort = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
    step();
    check_val("post_rst_idle", 96'({armed, done}), 96'(0));

    // 2. trigger before wrap
    scen_basic();
    // 3. wrap, ready high
    scen_wrap(0);
    // 4. backpressure
    scen_wrap(1);

    // 5. abort in POST, arm+abort together, then reproduce scenario 2
    trig_pc = 32'h08;
    do_arm();
    for (int i = 0; i < 4; i++) cap(32'(4 * i));
    do_abort();
    check_val("abort_state", 96'({armed, done, rd_valid, count}), 96'(0));
    arm = 1'b1;
    do_abort();
    arm = 1'b0;
    check_val("arm_abort", 96'({armed, count}), 96'(0));
    scen_basic();

    // 6. qualification: matches without cap_valid never trigger; arm in POST ignored
    trig_pc = 32'h20;
    do_arm();
    cap(32'h00);
    cap(32'h04);
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b0; cap_pc = 32'h20; step();
      check_val("qual_count", 96'({armed, count}), 96'({1'b1, 4'd2}));
    end
    cap(32'h20);
    do_arm();
    check_val("arm_in_post", 96'({armed, count}), 96'({1'b1, 4'd3}));
    cap(32'h24);
    cap(32'h28);
    check_val("qual_done", 96'(done), 96'(1));
    read_out(2);

    // randomized windows, gaps and readiness
    for (int r = 0; r < 4; r++) begin
      int npre;
      npre = $urandom_range(0, 12);
      trig_pc = 32'h100 + 32'(4 * npre);
      do_arm();
      for (int i = 0; i < npre + POST_TRIG + 3; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        cap(32'h100 + 32'(4 * i));
      end
      read_out(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
